// File: rtl/led_sched_pkg.sv
// led_sched_pkg: shared types and widths for the LED blink scheduler.
package led_sched_pkg;
    localparam int CODE_W = 4;
    localparam int TMR_W = 32;
    typedef enum logic [1:0] {IDLE, ON, OFF, GAP} state_t;
endpackage

// File: rtl/led_blink_scheduler_if.sv
// led_blink_scheduler_if: requester-side handshake bundle for the LED scheduler.
interface led_blink_scheduler_if
    import led_sched_pkg::*;
#(
    parameter int NUM_REQ = 4
);
    localparam int IW = $clog2(NUM_REQ);
    logic [NUM_REQ-1:0] req;
    logic [CODE_W*NUM_REQ-1:0] code;
    logic [NUM_REQ-1:0] ack;
    logic [IW-1:0] grant_id;
    logic busy;
    modport master (output req, code, input ack, grant_id, busy);
    modport slave (input req, code, output ack, grant_id, busy);
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, lowest index at or above ptr with wrap.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IW-1:0]      idx
);
    logic [IW-1:0] k;
    always_comb begin
        gnt = '0;
        idx = '0;
        k = '0;
        // scan from farthest to nearest so the closest requester wins last
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            k = IW'((int'(ptr) + i) % NUM_REQ);
            if (en && req[k]) begin
                idx = k;
                gnt = NUM_REQ'(1) << k;
            end
        end
    end
endmodule

// File: rtl/led_blink_scheduler.sv
// led_blink_scheduler: shares led_1 among requesters, playing each blink code in turn.
module led_blink_scheduler
    import led_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ON_CYCLES = 50_000_000,
    parameter int OFF_CYCLES = 50_000_000,
    parameter int GAP_CYCLES = 200_000_000
) (
    input  logic                  sys_clk_200m,
    input  logic                  sys_rst_n,
    led_blink_scheduler_if.slave  bus,
    output logic                  led_1
);
    localparam int IW = $clog2(NUM_REQ);
    localparam logic [TMR_W-1:0] ON_LD = TMR_W'(ON_CYCLES - 1);
    localparam logic [TMR_W-1:0] OFF_LD = TMR_W'(OFF_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_LD = TMR_W'(GAP_CYCLES - 1);

    state_t state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [CODE_W-1:0] rem_q, rem_d;
    logic [IW-1:0] ptr_q, ptr_d, gid_q, gid_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic led_q, led_d, busy_q, busy_d;
    logic [NUM_REQ-1:0] gnt;
    logic [IW-1:0] idx;
    logic [CODE_W-1:0] code_w;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
        return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
    endfunction

    // no grant while an ack is out, so the acked requester can drop req first
    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req (bus.req),
        .ptr (ptr_q),
        .en  (state_q == IDLE && ack_q == '0),
        .gnt (gnt),
        .idx (idx)
    );

    assign code_w = CODE_W'(bus.code >> (CODE_W * idx));

    always_comb begin
        state_d = state_q;
        tmr_d = tmr_q;
        rem_d = rem_q;
        ptr_d = ptr_q;
        gid_d = gid_q;
        ack_d = '0;
        unique case (state_q)
            IDLE: if (gnt != '0) begin
                gid_d = idx;
                rem_d = code_w;
                if (code_w == '0) begin
                    ack_d = gnt;
                    ptr_d = wrap_inc(idx);
                end else begin
                    state_d = ON;
                    tmr_d = ON_LD;
                end
            end
            ON: if (tmr_q == '0) begin
                rem_d = rem_q - 1'b1;
                if (rem_q == CODE_W'(1)) begin
                    state_d = GAP;
                    tmr_d = GAP_LD;
                    ack_d = NUM_REQ'(1) << gid_q;
                    ptr_d = wrap_inc(gid_q);
                end else begin
                    state_d = OFF;
                    tmr_d = OFF_LD;
                end
            end else tmr_d = tmr_q - 1'b1;
            OFF: if (tmr_q == '0) begin
                state_d = ON;
                tmr_d = ON_LD;
            end else tmr_d = tmr_q - 1'b1;
            GAP: if (tmr_q == '0) state_d = IDLE;
                 else tmr_d = tmr_q - 1'b1;
        endcase
        led_d = state_d == ON;
        busy_d = state_d != IDLE || ack_d != '0;
    end

    always_ff @(posedge sys_clk_200m or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            tmr_q <= '0;
            rem_q <= '0;
            ptr_q <= '0;
            gid_q <= '0;
            ack_q <= '0;
            led_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q <= tmr_d;
            rem_q <= rem_d;
            ptr_q <= ptr_d;
            gid_q <= gid_d;
            ack_q <= ack_d;
            led_q <= led_d;
            busy_q <= busy_d;
        end
    end

    assign bus.ack = ack_q;
    assign bus.grant_id = gid_q;
    assign bus.busy = busy_q;
    assign led_1 = led_q;
endmodule

// File: tb/tb_led_blink_scheduler.sv
// tb_led_blink_scheduler: directed checks of grant order, blink timing, zero codes and reset.
module tb_led_blink_scheduler;
    localparam int ON = 4;
    localparam int OFF = 3;
    localparam int GAP = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic led;
    int n_err = 0;
    int n_chk = 0;

    led_blink_scheduler_if #(.NUM_REQ(4)) bus ();

    led_blink_scheduler #(
        .NUM_REQ(4), .ON_CYCLES(ON), .OFF_CYCLES(OFF), .GAP_CYCLES(GAP)
    ) dut (
        .sys_clk_200m (clk),
        .sys_rst_n    (rst_n),
        .bus          (bus),
        .led_1        (led)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // entered just after the grant edge; leaves in the IDLE cycle after the gap
    task automatic serve(input int id, input int n, input int chg_at);
        logic [63:0] got, exp;
        logic early, bad;
        int len, c;
        len = n * ON + (n - 1) * OFF;
        got = '0;
        exp = '0;
        early = 1'b0;
        bad = 1'b0;
        c = 0;
        for (int p = 0; p < n; p++) begin
            for (int k = 0; k < ON; k++) begin
                exp = exp | (64'd1 << c);
                c++;
            end
            c += OFF;
        end
        check("grant_id", 64'(bus.grant_id), 64'(id));
        check("busy_on_grant", 64'(bus.busy), 64'd1);
        for (int i = 0; i < len; i++) begin
            got = got | (64'(led) << i);
            early = early | (bus.ack != '0);
            if (i == chg_at) begin
                bus.code = (bus.code & ~(16'hF << (4 * id))) | (16'h1 << (4 * id));
                bus.req = bus.req & ~(4'b1 << id);
            end
            tick();
        end
        check("led_pattern", got, exp);
        check("early_ack", 64'(early), 64'd0);
        check("ack", 64'(bus.ack), 64'd1 << id);
        check("led_at_ack", 64'(led), 64'd0);
        bus.req = bus.req & ~(4'b1 << id);
        for (int i = 0; i < GAP - 1; i++) begin
            tick();
            bad = bad | led | (bus.ack != '0) | ~bus.busy;
        end
        check("gap", 64'(bad), 64'd0);
        tick();
        check("idle_busy", 64'(bus.busy), 64'd0);
        check("idle_led", 64'(led), 64'd0);
    endtask

    initial begin
        bus.req = '0;
        bus.code = '0;
        tick();
        tick();
        check("rst_led", 64'(led), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_ack", 64'(bus.ack), 64'd0);
        check("rst_gid", 64'(bus.grant_id), 64'd0);
        rst_n = 1'b1;
        tick();
        // all four at once from pointer 0: served 0,1,2,3
        bus.code = 16'h1111;
        bus.req = 4'b1111;
        for (int g = 0; g < 4; g++) begin
            tick();
            serve(g, 1, -1);
        end
        // single three-pulse code on requester 1
        bus.code = 16'h0030;
        bus.req = 4'b0010;
        tick();
        serve(1, 3, -1);
        // pointer now 2: requester 3 beats requester 0
        bus.code = 16'h1001;
        bus.req = 4'b1001;
        tick();
        serve(3, 1, -1);
        tick();
        serve(0, 1, -1);
        // zero code: ack next cycle, no LED, one busy cycle
        bus.code = 16'h0000;
        bus.req = 4'b0100;
        tick();
        check("z_ack", 64'(bus.ack), 64'h4);
        check("z_busy", 64'(bus.busy), 64'd1);
        check("z_led", 64'(led), 64'd0);
        check("z_gid", 64'(bus.grant_id), 64'd2);
        bus.req = '0;
        tick();
        check("z_ack_clr", 64'(bus.ack), 64'd0);
        check("z_busy_clr", 64'(bus.busy), 64'd0);
        // code 5 granted, then code rewritten to 1 and req dropped
        bus.code = 16'h0005;
        bus.req = 4'b0001;
        tick();
        serve(0, 5, 6);
        // pointer 1 picks requester 2; reset mid pulse 2 returns pointer to 0
        bus.code = 16'h0301;
        bus.req = 4'b0101;
        tick();
        check("pre_rst_gid", 64'(bus.grant_id), 64'd2);
        repeat (8) tick();
        check("pre_rst_led", 64'(led), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_led", 64'(led), 64'd0);
        check("mid_rst_busy", 64'(bus.busy), 64'd0);
        check("mid_rst_ack", 64'(bus.ack), 64'd0);
        check("mid_rst_gid", 64'(bus.grant_id), 64'd0);
        #1 rst_n = 1'b1;
        tick();
        serve(0, 1, -1);
        tick();
        serve(2, 3, -1);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
